// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed seven-segment display driver. It drives one shared segment
//   bus and one enable line per digit.
//
//   Each digit slot has two phases:
//   - BLANK_CYCLES clocks with every anode off, so the segment bus can settle
//     without ghosting onto a neighbouring digit.
//   - DIGIT_CYCLES clocks in which the anode is lit for a brightness-dependent
//     part of the window.
//
//   seg_in and brightness are captured once per frame, so a frame never tears.
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-high reset
//   en          : scan enable; low forces IDLE and drops the partial frame
//   seg_in      : digit k pattern at [7k+6:7k], {g,f,e,d,c,b,a}, 1 = lit
//   brightness  : 0 = dimmest, 15 = full duty
//   seg_out     : shared segment bus (polarity from SEG_ACTIVE_LOW)
//   an_out      : one-hot digit enable (polarity from AN_ACTIVE_LOW)
//   frame_done  : one-cycle pulse during the last cycle of each full frame
//   dbg_state_o : current FSM state (IDLE=0, BLANK=1, ON=2)
//
// Valid/ready: this block has no handshakes. seg_in and brightness are sampled
// unconditionally at frame start, and frame_done is a pure status pulse.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
   parameter int NUM_DIGITS     = 2,
   parameter int DIGIT_CYCLES   = 64,
   parameter int BLANK_CYCLES   = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [7*NUM_DIGITS-1:0] seg_in,
   input  logic [3:0]              brightness,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done,
   output logic [1:0]              dbg_state_o
);

   localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   // One extra bit of headroom so on_len can hold DIGIT_CYCLES itself.
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int ON_STEP = DIGIT_CYCLES / 16;

   localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [7*NUM_DIGITS-1:0] snap_q, snap_d;
   logic [3:0]              bright_q, bright_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    fd_q, fd_d;

   logic [CNT_W-1:0]        on_len;
   logic [6:0]              seg_lit;
   logic [NUM_DIGITS-1:0]   an_lit;

   // State and output registers. Each output flop captures a decode of the
   // next state, so the outputs line up exactly with the registered state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         snap_q   <= '0;
         bright_q <= '0;
         seg_q    <= SEG_OFF;
         an_q     <= AN_OFF;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         snap_q   <= snap_d;
         bright_q <= bright_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         fd_q     <= fd_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      snap_d   = snap_q;
      bright_d = bright_q;

      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               snap_d   = seg_in;
               bright_d = brightness;
               idx_d    = '0;
               cnt_d    = '0;
               state_d  = BLANK;
            end
            BLANK: begin
               if (cnt_q == BLK_LAST) begin
                  cnt_d   = '0;
                  state_d = ON;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ON: begin
               if (cnt_q == DIG_LAST) begin
                  cnt_d   = '0;
                  state_d = BLANK;
                  if (idx_q == IDX_LAST) begin
                     // Frame boundary: this is the only point where new input
                     // values are accepted.
                     idx_d    = '0;
                     snap_d   = seg_in;
                     bright_d = brightness;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output decode of the next state.
   always_comb begin
      seg_lit = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) seg_lit = snap_d[7*k +: 7];
      end
      an_lit = NUM_DIGITS'(1) << idx_d;
      // The multiply is equivalent to ((bright+1)*DIGIT_CYCLES)>>4, because
      // DIGIT_CYCLES is a multiple of 16.
      on_len = CNT_W'((32'(bright_d) + 32'd1) * 32'(ON_STEP));

      seg_d = SEG_OFF;
      an_d  = AN_OFF;
      fd_d  = 1'b0;
      unique case (state_d)
         BLANK: begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
         end
         ON: begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
            if (cnt_d < on_len) an_d = (AN_ACTIVE_LOW != 0) ? ~an_lit : an_lit;
            fd_d  = (cnt_d == DIG_LAST) && (idx_d == IDX_LAST);
         end
         default: begin
            seg_d = SEG_OFF;
         end
      endcase
   end

   assign seg_out     = seg_q;
   assign an_out      = an_q;
   assign frame_done  = fd_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//   Directed bench for seven_seg_scanner. It uses NUM_DIGITS=2, DIGIT_CYCLES=16,
//   BLANK_CYCLES=2, and active-low segments and anodes.
//
//   A frame is 36 cycles. Position p within the frame maps as follows:
//   - digit = p/18, slot = p%18.
//   - Slots 0..1 are blank.
//   - Slots 2..17 are ON, and the anode is lit while slot-2 < brightness+1.
//   - frame_done is high at p=35.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

  logic        clk;
  logic        rst;
  logic        en;
  logic [13:0] seg_in;
  logic [3:0]  brightness;
  logic [6:0]  seg_out;
  logic [1:0]  an_out;
  logic        frame_done;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;
  int frame_pos;

  seven_seg_scanner #(
    .NUM_DIGITS    (2),
    .DIGIT_CYCLES  (16),
    .BLANK_CYCLES  (2),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seg_in     (seg_in),
    .brightness (brightness),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done),
    .dbg_state_o(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // At most one anode active, checked on every cycle.
  logic [1:0] an_n;
  always @(negedge clk) begin
    an_n = ~an_out;
    check("onehot_an", 32'($countones(an_n) <= 1), 32'd1);
  end

  task automatic check_idle(input string tag);
    check({tag, "_seg"}, 32'(seg_out), 32'h7F);
    check({tag, "_an"}, 32'(an_out), 32'h3);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  // Advance n cycles and compare against the frame model for digit patterns
  // d1/d0 at brightness br.
  task automatic run_cycles(input int n, input logic [6:0] d1, input logic [6:0] d0,
                            input int br);
    int         dig;
    int         p;
    logic [6:0] seg_e;
    logic [1:0] an_e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      dig   = frame_pos / 18;
      p     = frame_pos % 18;
      seg_e = (dig == 1) ? ~d1 : ~d0;
      an_e  = 2'b11;
      if (p >= 2 && (p - 2) < (br + 1)) an_e[dig] = 1'b0;
      check("seg_out", 32'(seg_out), 32'(seg_e));
      check("an_out", 32'(an_out), 32'(an_e));
      check("frame_done", 32'(frame_done), 32'(frame_pos == 35));
      frame_pos = (frame_pos + 1) % 36;
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    frame_pos  = 0;
    rst        = 1'b1;
    en         = 1'b0;
    seg_in     = '0;
    brightness = 4'd0;

    // Scenario 1: reset, then idle with en=0
    #1;
    check_idle("rst");
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("idle");
    end

    // Scenario 2: "1","0" at full brightness, two frames
    seg_in     = {7'h06, 7'h3F};
    brightness = 4'd15;
    en         = 1'b1;
    frame_pos  = 0;
    run_cycles(72, 7'h06, 7'h3F, 15);

    // Scenario 3: brightness 3 gives 4 lit cycles out of 16
    brightness = 4'd3;
    run_cycles(36, 7'h06, 7'h3F, 3);

    // Scenario 4: change seg_in during digit-1 ON; takes effect next frame
    brightness = 4'd15;
    run_cycles(24, 7'h06, 7'h3F, 15);
    seg_in = {7'h5B, 7'h4F};
    run_cycles(12, 7'h06, 7'h3F, 15);
    run_cycles(36, 7'h5B, 7'h4F, 15);

    // Scenario 5: drop en mid-ON of digit 0, then reassert
    run_cycles(10, 7'h5B, 7'h4F, 15);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("en_off");
      check("en_off_state", 32'(dbg_state), 32'd0);
    end
    en        = 1'b1;
    frame_pos = 0;
    run_cycles(36, 7'h5B, 7'h4F, 15);

    // Scenario 6: asynchronous reset mid-frame
    run_cycles(10, 7'h5B, 7'h4F, 15);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    check_idle("rst_held");
    rst       = 1'b0;
    frame_pos = 0;
    run_cycles(36, 7'h5B, 7'h4F, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed seven-segment display driver, directly downstream of century_clock.
- Consumes the per-digit 7-bit segment patterns (output_second_0, output_second_1, and any further digit outputs concatenated) and drives one shared segment bus plus one digit-enable line per digit.
- Adds inter-digit blanking against ghosting, per-frame input snapshot against tearing, and 16-level brightness PWM.

Parameters:
- NUM_DIGITS, 2: number of multiplexed digits; legal range 1..8.
- DIGIT_CYCLES, 64: clocks per digit on-window; must be a multiple of 16 and >=16.
- BLANK_CYCLES, 4: clocks with all anodes inactive before each digit; >=1.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when seg_out bit is 0.
- AN_ACTIVE_LOW, 1: 1 = digit enabled when an_out bit is 0.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: scan enable.
- seg_in, input, 7*NUM_DIGITS: digit k pattern at [7k+6:7k]; bit order {g,f,e,d,c,b,a}; 1 = segment lit. Digit 0 is rightmost (seconds units).
- brightness, input, 4: 0 = dimmest, 15 = full duty.
- seg_out, output, 7: shared segment bus, polarity per SEG_ACTIVE_LOW.
- an_out, output, NUM_DIGITS: one-hot digit enable, polarity per AN_ACTIVE_LOW.
- frame_done, output, 1: one-cycle pulse at the end of each full frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, idx=0, cnt=0, snapshot=0.
  - seg_out all segments off.
  - an_out all digits inactive.
  - frame_done=0.
- Registered outputs: all outputs are flops updated on the same edge as state. No combinational path from inputs to outputs.
- States: IDLE, BLANK, ON.
- IDLE:
  - Outputs inactive.
  - On a clk edge with en=1: snapshot<=seg_in, bright_q<=brightness, idx<=0, cnt<=0, go to BLANK.
- BLANK:
  - an_out inactive.
  - seg_out = snapshot digit idx; segments settle while all anodes are off.
  - cnt runs 0..BLANK_CYCLES-1; on the last count go to ON with cnt<=0.
- ON:
  - on_len = ((bright_q+1)*DIGIT_CYCLES)>>4.
  - an_out bit idx is active exactly while cnt<on_len; otherwise all anodes are inactive.
  - seg_out holds snapshot digit idx for the whole window.
  - cnt runs 0..DIGIT_CYCLES-1. On the last count:
    - idx<NUM_DIGITS-1: idx<=idx+1, go to BLANK.
    - idx==NUM_DIGITS-1: frame_done=1 for this one cycle; idx<=0; re-snapshot seg_in and brightness; go to BLANK.
- Frame period: exactly NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) clocks. No idle gap between frames.
- Tear-free: changes on seg_in or brightness mid-frame are invisible until the next frame boundary.
- en deassert, any state: on the next edge go to IDLE, all outputs inactive, idx=0, cnt=0. A partial frame is discarded and no frame_done is produced.
- en reasserted in IDLE: a fresh frame starts with BLANK of digit 0.
- Reset mid-frame: outputs go inactive immediately (asynchronously).
- Invariant: at most one an_out bit is active in any cycle, including the cycle of a digit change.

Test Plan:
- Bench parameters for all scenarios: NUM_DIGITS=2, DIGIT_CYCLES=16, BLANK_CYCLES=2, active-low both.
- Scenario 1: rst=1, then release with en=0 -> seg_out=7'b1111111, an_out=2'b11, frame_done=0 held indefinitely.
- Scenario 2: en=1, seg_in={7'h06,7'h3F} (digits "1","0"), brightness=15:
  - an_out=2'b11 for 2 cycles, then 2'b10 for 16 cycles with seg_out=~7'h3F.
  - Then 2'b11 for 2 cycles, then 2'b01 for 16 cycles with seg_out=~7'h06.
  - frame_done pulses on the 36th cycle; the pattern repeats every 36 cycles.
- Scenario 3: brightness=3 -> each digit is active for exactly 4 of its 16 ON cycles, then inactive for 12.
- Scenario 4: change seg_in to {7'h5B,7'h4F} during digit-1 ON -> the current frame still shows "1","0"; the next frame shows the new values.
- Scenario 5: drop en mid-ON of digit 0 -> an_out=2'b11 on the next edge; no frame_done. Reassert en -> 2 blank cycles, then digit 0.
- Scenario 6: assert rst asynchronously mid-frame -> an_out=2'b11 and seg_out=7'b1111111 before the next clk edge. Every-cycle check throughout: at most one an_out bit active.
